// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer and the decoder:
// the sequencer state encoding and the 32-bit instruction field layout.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Instruction layout: [31] mux, [30:25] rd, [24:19] rs, [18:15] op,
  // [14:9] rt, [8:0] imm.
  localparam int MUX_BIT = 31;
  localparam int RD_MSB  = 30;
  localparam int RD_LSB  = 25;
  localparam int RS_MSB  = 24;
  localparam int RS_LSB  = 19;
  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 15;
  localparam int RT_MSB  = 14;
  localparam int RT_LSB  = 9;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  // An all-zero op field marks an instruction that never writes a register.
  localparam logic [3:0] OP_NOP = 4'b0000;

  function automatic logic [3:0] op_of(input logic [31:0] inst);
    return inst[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC (ALU_LAT cycles)
// -> WB for each of prog_len instructions, starting at pc 0 on a start pulse.
// Optional build macro SEQ_NOP_SKIP_EN: an acked NOP goes straight from FETCH
// to the pc-advance / termination decision, costing one cycle.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] prog_len,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     inst_q,
  output logic            exec_en,
  output logic            wb_en,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] len_q, len_d;
  logic [31:0]     inst_d;
  logic [3:0]      lat_q, lat_d;
  logic            last_w;

  // The last-index compare ends the program before pc could ever wrap.
  assign last_w = (pc_q == len_q - PC_W'(1));

  // State and datapath registers; reset clears everything and beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      inst_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      inst_q  <= inst_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE, ack only in FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    inst_d  = inst_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          inst_d = imem_data;
`ifdef SEQ_NOP_SKIP_EN
          if (op_of(imem_data) == OP_NOP) begin
            if (last_w) begin
              state_d = DONE;
            end else begin
              pc_d    = pc_q + PC_W'(1);
              state_d = FETCH;
            end
          end else begin
            state_d = DECODE;
          end
`else
          state_d = DECODE;
`endif
        end
      end
      DECODE: begin
        lat_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        lat_d = lat_q + 4'd1;
        if (lat_q == LAT_LAST) begin
          state_d = WB;
        end
      end
      WB: begin
        if (last_w) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    imem_req  = (state_q == FETCH);
    imem_addr = pc_q;
    exec_en   = (state_q == EXEC);
    wb_en     = (state_q == WB) && (op_of(inst_q) != OP_NOP);
    pc        = pc_q;
    busy      = (state_q != IDLE) && (state_q != DONE);
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: a memory responder with
// programmable ack delay, a reference model that predicts fetch, write-back
// and done events with their cycle numbers, and a monitor that compares them.
module tb_inst_sequencer;

  localparam int PC_W = 8;
  localparam int LAT  = 1;
`ifdef SEQ_NOP_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam int EV_FETCH = 0;
  localparam int EV_WB    = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [PC_W-1:0] prog_len = '0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_data = '0;
  logic [31:0]     inst_q;
  logic            exec_en, wb_en, busy, done;
  logic [PC_W-1:0] pc;

  logic [31:0] mem [256];
  ev_t         sb[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int ack_delay = 0, wcnt = 0;
  bit stray = 1'b0;
  int req_cyc, busy_cyc, exec_cyc, done_cyc;
  int exp_req, exp_busy, exp_exec, start_cyc;

  inst_sequencer #(.PC_W(PC_W), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .inst_q(inst_q), .exec_en(exec_en),
    .wb_en(wb_en), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input int tag);
    return {1'b1, 6'(tag), 6'(tag + 3), op, 6'(tag + 7), 9'(tag * 5 + 1)};
  endfunction

  // Instruction memory: acks a request after ack_delay waiting cycles;
  // optionally fires spurious acks with junk data while no fetch is pending.
  always @(posedge clk) begin
    #2;
    if (imem_req) begin
      if (wcnt == ack_delay) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wcnt      = 0;
      end else begin
        imem_ack  = 1'b0;
        wcnt      = wcnt + 1;
      end
    end else begin
      imem_ack  = stray;
      imem_data = stray ? 32'hFFFF_FFFF : 32'h0;
      wcnt      = 0;
    end
  end

  task automatic observe(input int kind, input logic [31:0] val);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL unexpected_event kind=%0d cyc=%0d val=%0h expected=none", kind, cyc, val);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_cycle", 32'(cyc), 32'(e.cyc));
      chk("ev_value", val, e.val);
    end
  endtask

  // Monitor: sample mid-cycle and turn DUT activity into events.
  always @(negedge clk) begin
    if (!reset) begin
      if (exec_en || wb_en) chk("exec_wb_exclusive", {31'b0, exec_en && wb_en}, 32'h0);
      if (imem_req) req_cyc++;
      if (busy) busy_cyc++;
      if (exec_en) exec_cyc++;
      if (imem_req && imem_ack) observe(EV_FETCH, 32'(imem_addr));
      if (wb_en) observe(EV_WB, inst_q);
      if (done) begin
        done_cyc = cyc;
        chk("busy_during_done", {31'b0, busy}, 32'h0);
        observe(EV_DONE, 32'(pc));
      end
    end
  end

  // Predict the event stream for a program, then pulse start.
  task automatic start_prog(input int n, input int d);
    int f, ack, wb;
    @(posedge clk); #1;
    ack_delay = d;
    req_cyc = 0; busy_cyc = 0; exec_cyc = 0; done_cyc = -1;
    exp_req = 0; exp_exec = 0;
    start_cyc = cyc;
    f = cyc + 1;
    for (int i = 0; i < n; i++) begin
      ack = f + d;
      sb.push_back('{EV_FETCH, ack, 32'(i)});
      exp_req += d + 1;
      if (SKIP && mem[i][18:15] == 4'h0) begin
        f = ack + 1;
      end else begin
        wb = ack + 2 + LAT;
        if (mem[i][18:15] != 4'h0) sb.push_back('{EV_WB, wb, mem[i]});
        exp_exec += LAT;
        f = wb + 1;
      end
    end
    sb.push_back('{EV_DONE, f, (n == 0) ? 32'h0 : 32'(n - 1)});
    exp_busy = f - (start_cyc + 1);
    start = 1'b1;
    prog_len = PC_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_prog(input string name);
    for (int k = 0; k < 3000; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'h0);
    sb.delete();
    chk({name, "_req_cycles"}, 32'(req_cyc), 32'(exp_req));
    chk({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
    chk({name, "_exec_cycles"}, 32'(exec_cyc), 32'(exp_exec));
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = mk(4'((i % 15) + 1), i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_inst", inst_q, 32'h0);
    reset = 1'b0;

    // Three instructions, zero-wait ack, spurious acks outside FETCH
    mem[0] = mk(4'h1, 10); mem[1] = mk(4'h2, 20); mem[2] = mk(4'h3, 30);
    stray = 1'b1;
    start_prog(3, 0);
    finish_prog("prog3");
    chk("prog3_total_cycles", 32'(done_cyc - start_cyc), 32'd13);
    stray = 1'b0;

    // Empty program
    start_prog(0, 0);
    finish_prog("len0");
    chk("len0_done_offset", 32'(done_cyc - start_cyc), 32'd1);

    // Slow memory: five wait cycles before ack
    start_prog(1, 5);
    finish_prog("slowack");
    chk("slowack_req_cycles_abs", 32'(req_cyc), 32'd6);

    // Second instruction is a NOP
    mem[0] = mk(4'h5, 40); mem[1] = mk(4'h0, 50);
    start_prog(2, 0);
    finish_prog("nop");
    chk("nop_done_offset", 32'(done_cyc - start_cyc), SKIP ? 32'd6 : 32'd9);

    // Reset during EXEC of instruction 1, then restart with a mid-run start
    mem[0] = mk(4'h1, 60); mem[1] = mk(4'h2, 61); mem[2] = mk(4'h3, 62);
    start_prog(3, 0);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (exec_en && pc == 1) begin found = 1'b1; break; end
    end
    chk("reach_exec_pc1", {31'b0, found}, 32'h1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    chk("midrst_exec", {31'b0, exec_en}, 32'h0);
    chk("midrst_wb", {31'b0, wb_en}, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_pc", 32'(pc), 32'h0);
    chk("midrst_inst", inst_q, 32'h0);
    reset = 1'b0;
    start_prog(3, 0);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    prog_len = PC_W'(1);
    @(posedge clk); #1;
    start = 1'b0;
    finish_prog("restart");

    // Longest program: pc must reach 254 and stop without wrapping
    start_prog(255, 0);
    finish_prog("maxlen");
    chk("maxlen_final_pc", 32'(pc), 32'd254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
